// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
// Processor stores to TXDATA queue bytes in a small FIFO. A TX FSM
// pops them one at a time and shifts each out on Tx as an 8N1 frame.
// STATUS reports FIFO fill, frame activity and a sticky overflow flag.
//
// Bus handshake: there is no valid/ready pair. A store is a single-cycle
// strobe (MemWrite) that is always accepted. When the FIFO is full, the
// byte is dropped and the overflow flag records the loss.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        Sel,
    output logic        Tx,
    output logic        Busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Registers
    state_t         r_state;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_ovf;
    logic [7:0]     r_shift;
    logic [2:0]     r_bit_idx;
    logic [TW-1:0]  r_timer;
    logic           r_tx;

    // Wires
    state_t         w_state_next;
    logic           w_hit;
    logic           w_wr_data;
    logic           w_wr_stat;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_drop;
    logic           w_clr_ovf;
    logic           w_pop;
    logic           w_tick;
    logic           w_last_bit;
    logic [7:0]     w_shift_next;
    logic [2:0]     w_bit_idx_next;
    logic [TW-1:0]  w_timer_next;
    logic           w_tx_next;
    logic [31:0]    w_count_ext;
    logic [3:0]     w_cnt_disp;
    logic [31:0]    w_status;
    logic           w_unused_bits;

    // Address decode: byte lanes DataAdr[1:0] do not affect register selection
    assign w_hit     = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign w_wr_data = MemWrite & w_hit & ~DataAdr[2];
    assign w_wr_stat = MemWrite & w_hit &  DataAdr[2];
    assign w_clr_ovf = w_wr_stat & WriteData[3];

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle
    assign w_push = w_wr_data & ~w_full;
    assign w_drop = w_wr_data &  w_full;

    assign w_tick     = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign w_last_bit = (r_bit_idx == 3'd7);

    assign w_count_ext = 32'(r_count);
    assign w_cnt_disp  = (w_count_ext > 32'd15) ? 4'hF : w_count_ext[3:0];
    assign w_status    = {24'h0, w_cnt_disp, r_ovf, (r_state != S_IDLE), w_empty, w_full};

    assign Sel    = w_hit;
    assign RdData = (w_hit && DataAdr[2]) ? w_status : 32'h0;
    assign Tx     = r_tx;
    assign Busy   = (r_state != S_IDLE) | ~w_empty;

    assign w_unused_bits = ^{DataAdr[1:0], WriteData[31:8]};

    // FIFO storage: written on accepted pushes only; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // TX FSM state register plus the datapath it steers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_timer   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_timer   <= w_timer_next;
            r_tx      <= w_tx_next;
        end
    end

    // TX FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty)              w_state_next = S_START;
            S_START: if (w_tick)                w_state_next = S_DATA;
            S_DATA:  if (w_tick && w_last_bit)  w_state_next = S_STOP;
            S_STOP:  if (w_tick)                w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    // TX FSM outputs: pop, datapath next values, and the next Tx level
    always_comb begin
        w_pop          = 1'b0;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_timer_next   = r_timer;
        w_tx_next      = 1'b1;
        if (r_state == S_IDLE) begin
            if (!w_empty) begin
                w_pop          = 1'b1;
                w_shift_next   = r_mem[r_rd_ptr];
                w_bit_idx_next = '0;
                w_timer_next   = '0;
            end
        end else if (w_tick) begin
            w_timer_next = '0;
            if (r_state == S_DATA) begin
                w_shift_next   = r_shift >> 1;
                w_bit_idx_next = r_bit_idx + 1'b1;
            end
        end else begin
            w_timer_next = r_timer + 1'b1;
        end
        // Tx is registered, so it is derived from the state being entered
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Inputs are driven 2 time units after each rising edge. A serial
// monitor samples Tx on falling edges and checks each frame bit by bit
// against the byte at the head of exp_q.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] RdData;
    logic        Sel;
    logic        Tx;
    logic        Busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_count = 0;
    int frames_seen = 0;
    logic in_frame = 1'b0;
    logic [7:0] exp_q[$];
    int start_q[$];

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .RdData(RdData),
        .Sel(Sel),
        .Tx(Tx),
        .Busy(Busy)
    );

    // Clock and cycle counter (cyc = N after rising edge N)
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serial monitor / scoreboard
    initial begin : monitor
        int pos;
        logic [7:0] cur;
        logic [7:0] obs;
        logic bad;
        logic exp_bit;
        pos = 0; cur = 8'h0; obs = 8'h0; bad = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && Tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos = 0; bad = 1'b0; obs = 8'h0;
                    start_q.push_back(cyc);
                    frames_seen++;
                    if (model_count > 0) model_count--;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        cur = 8'h00;
                        $display("FAIL unexpected_frame: start bit seen at cycle %0d, expected no frame", cyc);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (in_frame) begin
                    if (pos < CPB)            exp_bit = 1'b0;
                    else if (pos < 9 * CPB)   exp_bit = cur[(pos - CPB) / CPB];
                    else                      exp_bit = 1'b1;
                    if (Tx !== exp_bit) bad = 1'b1;
                    if (pos >= CPB && pos < 9 * CPB && ((pos - CPB) % CPB) == 1)
                        obs[(pos - CPB) / CPB] = Tx;
                    pos++;
                    if (pos == 10 * CPB) begin
                        in_frame = 1'b0;
                        checks++;
                        if (bad) begin
                            errors++;
                            $display("FAIL frame_bits: got byte %02h (or wrong bit timing), expected %02h", obs, cur);
                        end
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_set(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
        if (we && ((a >> 3) == (BASE >> 3)) && !a[2]) begin
            if (model_count < DEPTH) begin
                exp_q.push_back(d[7:0]);
                model_count++;
            end
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_set(1'b1, a, d);
        tick();
        bus_set(1'b0, 32'h0, 32'h0);
    endtask

    task automatic read_status(output logic [31:0] v);
        bus_set(1'b0, BASE + 32'h4, 32'h0);
        #1;
        v = RdData;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while ((Busy !== 1'b0 || in_frame || exp_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, max);
        end
    endtask

    // Tests
    task automatic test_reset();
        logic [31:0] st;
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        checks++;
        if (Tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", Tx); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        read_status(st);
        checks++;
        if (st !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %08h expected 00000002", st); end
        checks++;
        if (Sel !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b expected 1", Sel); end
        bus_set(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_single();
        int c0;
        int last_busy;
        logic [31:0] st;
        start_q.delete();
        c0 = cyc;
        store(BASE, 32'h0000_00A5);
        // cycle c0+1: the byte is counted, FSM still idle
        read_status(st);
        checks++;
        if (st !== 32'h0000_0010) begin errors++; $display("FAIL single_status: got %08h expected 00000010", st); end
        bus_set(1'b0, 32'h0, 32'h0);
        last_busy = -1;
        for (int i = 0; i < 45; i++) begin
            if (Busy === 1'b1) last_busy = cyc;
            tick();
        end
        checks++;
        if (last_busy != c0 + 1 + 10 * CPB) begin
            errors++;
            $display("FAIL single_busy_drop: last busy cycle %0d expected %0d", last_busy, c0 + 1 + 10 * CPB);
        end
        checks++;
        if (start_q.size() != 1 || start_q[0] != c0 + 2) begin
            errors++;
            $display("FAIL single_start: %0d starts, first at %0d, expected 1 start at %0d",
                     start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, c0 + 2);
        end
        wait_idle("single", 100);
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [31:0] st;
        start_q.delete();
        c0 = cyc;
        bus_set(1'b1, BASE, 32'h11); tick();
        bus_set(1'b1, BASE, 32'h22); tick();
        bus_set(1'b1, BASE, 32'h33); tick();
        // pushes at E1,E2,E3 and one pop at E2 leave two queued, frame active
        read_status(st);
        checks++;
        if (st !== 32'h0000_0024) begin errors++; $display("FAIL b2b_status: got %08h expected 00000024", st); end
        bus_set(1'b0, 32'h0, 32'h0);
        wait_idle("b2b", 300);
        checks++;
        if (start_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_frames: got %0d frames expected 3", start_q.size());
        end else begin
            checks++;
            if (start_q[0] != c0 + 2) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", start_q[0], c0 + 2); end
            checks++;
            if (start_q[1] - start_q[0] != 10 * CPB + 1) begin errors++; $display("FAIL b2b_pitch1: got %0d expected %0d", start_q[1] - start_q[0], 10 * CPB + 1); end
            checks++;
            if (start_q[2] - start_q[1] != 10 * CPB + 1) begin errors++; $display("FAIL b2b_pitch2: got %0d expected %0d", start_q[2] - start_q[1], 10 * CPB + 1); end
        end
    endtask

    task automatic test_overflow();
        int f0;
        logic [31:0] st;
        f0 = frames_seen;
        store(BASE, 32'h5A);
        tick();
        // frame for 0x5A is active; the FIFO is empty and nothing pops for ~38 cycles
        for (int i = 0; i < 10; i++) begin
            bus_set(1'b1, BASE, 32'h80 + i);
            tick();
        end
        bus_set(1'b0, 32'h0, 32'h0);
        read_status(st);
        checks++;
        if (st !== 32'h0000_008D) begin errors++; $display("FAIL ovf_status: got %08h expected 0000008D", st); end
        store(BASE + 32'h4, 32'h8);
        read_status(st);
        checks++;
        if (st !== 32'h0000_0085) begin errors++; $display("FAIL ovf_clear: got %08h expected 00000085", st); end
        bus_set(1'b0, 32'h0, 32'h0);
        wait_idle("ovf", 600);
        checks++;
        if (frames_seen - f0 != 9) begin errors++; $display("FAIL ovf_frames: got %0d frames expected 9", frames_seen - f0); end
    endtask

    task automatic test_reset_mid();
        int c0;
        int f0;
        logic tx_bad;
        logic [31:0] st;
        c0 = cyc;
        store(BASE, 32'h3C);
        store(BASE, 32'h96);
        while (cyc < c0 + 2 + CPB + 9) tick();
        reset = 1'b1;
        exp_q.delete();
        model_count = 0;
        tick();
        reset = 1'b0;
        checks++;
        if (Tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", Tx); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
        read_status(st);
        checks++;
        if (st !== 32'h0000_0002) begin errors++; $display("FAIL rstmid_status: got %08h expected 00000002", st); end
        bus_set(1'b0, 32'h0, 32'h0);
        f0 = frames_seen;
        tx_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (Tx !== 1'b1) tx_bad = 1'b1;
            tick();
        end
        checks++;
        if (tx_bad || frames_seen != f0) begin
            errors++;
            $display("FAIL rstmid_quiet: tx_low=%b frames=%0d expected tx_low=0 frames=0", tx_bad, frames_seen - f0);
        end
    endtask

    task automatic test_window();
        int f0;
        logic quiet_bad;
        f0 = frames_seen;
        bus_set(1'b1, BASE + 32'h8, 32'h77);
        #1;
        checks++;
        if (Sel !== 1'b0 || RdData !== 32'h0) begin errors++; $display("FAIL win_408: sel=%b rd=%08h expected sel=0 rd=0", Sel, RdData); end
        tick();
        bus_set(1'b1, BASE - 32'h4, 32'h66);
        #1;
        checks++;
        if (Sel !== 1'b0 || RdData !== 32'h0) begin errors++; $display("FAIL win_3fc: sel=%b rd=%08h expected sel=0 rd=0", Sel, RdData); end
        tick();
        bus_set(1'b0, 32'h0, 32'h0);
        quiet_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Tx !== 1'b1 || Busy !== 1'b0) quiet_bad = 1'b1;
            tick();
        end
        checks++;
        if (quiet_bad) begin errors++; $display("FAIL win_quiet: tx or busy moved after out-of-window stores, expected idle"); end
        bus_set(1'b1, BASE + 32'h2, 32'hC3);
        #1;
        checks++;
        if (Sel !== 1'b1 || RdData !== 32'h0) begin errors++; $display("FAIL win_402: sel=%b rd=%08h expected sel=1 rd=0", Sel, RdData); end
        tick();
        bus_set(1'b0, 32'h0, 32'h0);
        wait_idle("win", 100);
        checks++;
        if (frames_seen - f0 != 1) begin errors++; $display("FAIL win_frames: got %0d frames expected 1", frames_seen - f0); end
    endtask

    // Sequencer
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_window();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
